instr_fetch_unit: RTL and testbench

//  Requester side of the word-addressed instruction memory port. Holds the PC,

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. Fetches one word per cycle from a combinational
// instruction memory into a 2-entry prefetch queue and hands words to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_dword,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] deliver_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc    [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_misalign;
    logic [31:0] r_deliver_cnt;

    logic        w_pop;
    logic        w_push;
    logic        w_not_full;

    assign imem_addr    = r_pc[31:2];
    assign out_valid    = (r_count != 2'd0);
    assign out_instr    = r_q_instr[r_rd_ptr];
    assign out_pc       = r_q_pc[r_rd_ptr];
    assign halted       = (r_state == S_HALT) && (r_count == 2'd0);
    assign misalign_err = r_misalign;
    assign deliver_cnt  = r_deliver_cnt;

    assign w_not_full = (r_count < 2'(QDEPTH));
    assign w_pop      = out_valid & out_ready;
    assign w_push     = (r_state == S_RUN) & ~redirect_valid & ~halt_req & (w_not_full | w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = halt_req ? S_HALT : S_RUN;
            S_RUN:   if (halt_req) w_state_nxt = S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
        // Redirect overrides halt and boot sequencing.
        if (redirect_valid) w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC & ~32'd3;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_misalign    <= 1'b0;
            r_deliver_cnt <= 32'd0;
            r_q_instr[0]  <= 32'd0;
            r_q_instr[1]  <= 32'd0;
            r_q_pc[0]     <= 32'd0;
            r_q_pc[1]     <= 32'd0;
        end else begin
            if (w_pop) r_deliver_cnt <= r_deliver_cnt + 32'd1;
            if (redirect_valid) begin
                // The pop in this cycle still counts; the queue is then discarded.
                r_pc     <= redirect_pc & ~32'd3;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
                if (redirect_pc[1:0] != 2'b00) r_misalign <= 1'b1;
            end else begin
                if (w_push) begin
                    r_q_instr[r_wr_ptr] <= imem_dword;
                    r_q_pc[r_wr_ptr]    <= r_pc;
                    r_wr_ptr            <= ~r_wr_ptr;
                    r_pc                <= r_pc + 32'd4;
                end
                if (w_pop) r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns 0xA000_0000 + word address.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] imem_addr;
    logic [31:0] imem_dword;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign_err;
    logic [31:0] deliver_cnt;

    int n_total = 0;
    int n_fail  = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0040), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_dword(imem_dword),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .halted(halted), .misalign_err(misalign_err), .deliver_cnt(deliver_cnt)
    );

    assign imem_dword = 32'hA000_0000 + {2'b00, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_req = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_addr",   {2'b00, imem_addr}, 32'h10);
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_cnt",    deliver_cnt, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_mis",    {31'd0, misalign_err}, 32'd0);
        check("rst_pc",     out_pc, 32'd0);
        check("rst_instr",  out_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // boot cycle: no push
        step();
        check("boot_valid", {31'd0, out_valid}, 32'd0);
        check("boot_addr",  {2'b00, imem_addr}, 32'h10);
        step();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_pc",    out_pc, 32'h40);
        check("first_instr", out_instr, 32'hA000_0010);
        check("first_addr",  {2'b00, imem_addr}, 32'h11);

        // streaming
        out_ready = 1'b1;
        step();
        check("s1_pc",  out_pc, 32'h44);
        check("s1_cnt", deliver_cnt, 32'd1);
        step();
        check("s2_pc",  out_pc, 32'h48);
        check("s2_cnt", deliver_cnt, 32'd2);
        step();
        check("s3_pc",    out_pc, 32'h4C);
        check("s3_instr", out_instr, 32'hA000_0013);
        check("s3_cnt",   deliver_cnt, 32'd3);

        // backpressure: queue fills, address freezes at head+8
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("bp_pc",    out_pc, 32'h4C);
        check("bp_instr", out_instr, 32'hA000_0013);
        check("bp_addr",  {2'b00, imem_addr}, 32'h15);
        check("bp_cnt",   deliver_cnt, 32'd3);
        out_ready = 1'b1;
        step();
        check("rel_pc",   out_pc, 32'h50);
        check("rel_cnt",  deliver_cnt, 32'd4);
        check("rel_addr", {2'b00, imem_addr}, 32'h16);

        // redirect while full, misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", {31'd0, out_valid}, 32'd0);
        check("rd_cnt",   deliver_cnt, 32'd5);
        check("rd_mis",   {31'd0, misalign_err}, 32'd1);
        check("rd_addr",  {2'b00, imem_addr}, 32'h40);
        step();
        check("rd_pc",    out_pc, 32'h100);
        check("rd_instr", out_instr, 32'hA000_0040);

        // halt with one entry held, then drain
        out_ready = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("h_halted", {31'd0, halted}, 32'd0);
        check("h_valid",  {31'd0, out_valid}, 32'd1);
        check("h_addr",   {2'b00, imem_addr}, 32'h41);
        step();
        check("h_addr2",  {2'b00, imem_addr}, 32'h41);
        check("h_pc2",    out_pc, 32'h100);
        out_ready = 1'b1;
        step();
        check("h_done",   {31'd0, halted}, 32'd1);
        check("h_valid0", {31'd0, out_valid}, 32'd0);
        check("h_cnt",    deliver_cnt, 32'd6);
        step();
        check("h_stay",   {31'd0, halted}, 32'd1);
        check("h_addr3",  {2'b00, imem_addr}, 32'h41);

        // leave halt by redirect
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("hr_halted", {31'd0, halted}, 32'd0);
        check("hr_addr",   {2'b00, imem_addr}, 32'h80);
        step();
        check("hr_pc",    out_pc, 32'h200);
        check("hr_instr", out_instr, 32'hA000_0080);

        // wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("w_cnt",   deliver_cnt, 32'd7);
        check("w_addr",  {2'b00, imem_addr}, 32'h3FFF_FFFF);
        check("w_mis",   {31'd0, misalign_err}, 32'd1);
        step();
        check("w_pc",    out_pc, 32'hFFFF_FFFC);
        check("w_instr", out_instr, 32'hDFFF_FFFF);
        check("w_addr2", {2'b00, imem_addr}, 32'h0);
        step();
        check("w_pc0",    out_pc, 32'h0);
        check("w_instr0", out_instr, 32'hA000_0000);
        check("w_cnt2",   deliver_cnt, 32'd8);

        // asynchronous reset mid-cycle
        #1 rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_cnt",   deliver_cnt, 32'd0);
        check("ar_addr",  {2'b00, imem_addr}, 32'h10);
        check("ar_mis",   {31'd0, misalign_err}, 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
